// File: rtl/mvm_frame_tx.sv
// Transmit frame source for mvm3: buffers host words, streams only whole frames.
// Optional MVM_TX_THROTTLE_EN inserts LFSR-driven gaps before m_valid rises.
module mvm_frame_tx #(
  parameter  int SIZE   = 3,
  parameter  int WIDTH  = 8,
  parameter  int FRAMES = 2,
  localparam int TOTAL  = SIZE*SIZE+SIZE,
  localparam int DEPTH  = FRAMES*TOTAL,
  localparam int LW     = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             frame_done,
  output logic [LW-1:0]    level
);

  localparam int PW = $clog2(DEPTH);
  localparam int IW = $clog2(TOTAL);
  localparam int CW = $clog2(FRAMES+1);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]    wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CW-1:0]    committed_q, committed_d;
  logic             frame_done_q, frame_done_d;
  logic             wr_fire_s, rd_fire_s, commit_s, finish_s, send_ok_s;

`ifdef MVM_TX_THROTTLE_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        held_q, held_d;

  // Once raised, m_valid is held regardless of the LFSR until the handshake.
  always_comb begin
    send_ok_s = held_q || lfsr_q[0];
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    held_d    = m_valid && !m_ready;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q <= 16'hACE1;
      held_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      held_q <= held_d;
    end
  end
`else
  assign send_ok_s = 1'b1;
`endif

  always_comb begin
    wr_ready   = (level_q < LW'(DEPTH));
    wr_fire_s  = wr_valid && wr_ready;
    m_valid    = (state_q == SEND) && send_ok_s;
    m_data     = m_valid ? mem_q[rd_ptr_q] : {WIDTH{1'b0}};
    rd_fire_s  = m_valid && m_ready;
    commit_s   = wr_fire_s && (wr_idx_q == IW'(TOTAL-1));
    finish_s   = rd_fire_s && (rd_idx_q == IW'(TOTAL-1));
    frame_done = frame_done_q;
    level      = level_q;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    level_d      = level_q;
    committed_d  = committed_q;
    state_d      = state_q;
    frame_done_d = finish_s;

    if (wr_fire_s) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? {PW{1'b0}} : wr_ptr_q + PW'(1);
      wr_idx_d = (wr_idx_q == IW'(TOTAL-1)) ? {IW{1'b0}} : wr_idx_q + IW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_fire_s) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? {PW{1'b0}} : rd_ptr_q + PW'(1);
      rd_idx_d = (rd_idx_q == IW'(TOTAL-1)) ? {IW{1'b0}} : rd_idx_q + IW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_fire_s, rd_fire_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    case ({commit_s, finish_s})
      2'b10:   committed_d = committed_q + CW'(1);
      2'b01:   committed_d = committed_q - CW'(1);
      default: committed_d = committed_q;
    endcase

    // Back-to-back frames: stay in SEND when another frame remains committed.
    case (state_q)
      IDLE: state_d = (committed_q != {CW{1'b0}}) ? SEND : IDLE;
      SEND: begin
        if (finish_s) begin
          state_d = (committed_d != {CW{1'b0}}) ? SEND : IDLE;
        end else begin
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= {PW{1'b0}};
      rd_ptr_q     <= {PW{1'b0}};
      wr_idx_q     <= {IW{1'b0}};
      rd_idx_q     <= {IW{1'b0}};
      level_q      <= {LW{1'b0}};
      committed_q  <= {CW{1'b0}};
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      level_q      <= level_d;
      committed_q  <= committed_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_mvm_frame_tx.sv
// Bench for mvm_frame_tx: a queue-based model of the frame buffer checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_mvm_frame_tx;
  localparam int TOTAL = 12;
  localparam int DEPTH = 24;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_valid = 1'b0;
  logic       m_ready = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, m_valid, frame_done;
  logic [7:0] m_data;
  logic [4:0] level;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic [7:0] exp_q[$];
  int  wr_cnt = 0, rd_cnt = 0;
  int  fd_dut = 0, gap_cnt = 0;
  bit  armed = 0, stall_prev = 0, cont_prev = 0, fd_exp = 0;
  logic [7:0] prev_data = 8'h00;

  mvm_frame_tx #(.SIZE(3), .WIDTH(8), .FRAMES(2)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .frame_done(frame_done), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the queue model; then advance the model for the next edge.
  always @(negedge clk) begin
    bit rd, wr;
    if (armed) begin
      chk("level", level, wr_cnt - rd_cnt);
      chk("wr_ready", wr_ready, (wr_cnt - rd_cnt) < DEPTH);
      chk("frame_done", frame_done, fd_exp);
      if (m_valid === 1'b1) begin
        chk("partial_frame", ((rd_cnt / TOTAL) + 1) * TOTAL <= wr_cnt, 1);
        if (exp_q.size() > 0) chk("m_data", m_data, exp_q[0]);
        else chk("m_data_empty", m_valid, 0);
      end else begin
        chk("m_data_idle", m_data, 0);
        chk("m_valid_known", m_valid, 0);
      end
      if (stall_prev) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
      end
`ifndef MVM_TX_THROTTLE_EN
      if (cont_prev) chk("gapless", m_valid, 1);
`endif
      if (frame_done === 1'b1) fd_dut++;
      if (m_valid !== 1'b1 && (rd_cnt % TOTAL) != 0) gap_cnt++;
    end
    if (reset === 1'b0) begin
      exp_q.delete();
      wr_cnt = 0; rd_cnt = 0;
      armed = 1; stall_prev = 0; cont_prev = 0; fd_exp = 0;
    end else if (armed) begin
      rd = (m_valid === 1'b1) && (m_ready === 1'b1);
      wr = (wr_valid === 1'b1) && ((wr_cnt - rd_cnt) < DEPTH);
      stall_prev = (m_valid === 1'b1) && (m_ready !== 1'b1);
      prev_data  = m_data;
      if (rd) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        rd_cnt++;
      end
      fd_exp    = rd && (rd_cnt % TOTAL == 0);
      cont_prev = rd && (rd_cnt % TOTAL != 0);
      if (wr) begin
        exp_q.push_back(wr_data);
        wr_cnt++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_word(input logic [7:0] d);
    int k = 0;
    bit ok = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    while (!ok && k < 500) begin
      @(negedge clk);
      ok = (wr_ready === 1'b1);
      @(posedge clk);
      #1;
      k++;
    end
    wr_valid = 1'b0;
    if (!ok) chk("write_timeout", 0, 1);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (level !== 5'd0 && k < budget) begin
      cyc(1);
      k++;
    end
    chk("drain_timeout", level, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;
    bit wdone;
    reset = 1'b0;
    cyc(2);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_level", level, 0);
    chk("rst_wr_ready", wr_ready, 1);
    reset = 1'b1;

`ifndef MVM_TX_THROTTLE_EN
    // one frame 01..0C streamed gaplessly
    m_ready = 1'b1;
    for (int i = 1; i <= 12; i++) write_word(8'(i));
    chk("t1_not_yet", m_valid, 0);
    cyc(1);
    for (int i = 1; i <= 12; i++) begin
      chk("t1_valid", m_valid, 1);
      chk("t1_data", m_data, i);
      cyc(1);
    end
    chk("t1_done", frame_done, 1);
    chk("t1_valid_off", m_valid, 0);
    chk("t1_level", level, 0);
    cyc(1);
    chk("t1_done_pulse", frame_done, 0);

    // partial frame holds back m_valid
    for (int i = 0; i < 11; i++) write_word(8'(8'h20 + i));
    cyc(20);
    chk("t2_partial", m_valid, 0);
    chk("t2_level", level, 11);
    write_word(8'h2B);
    chk("t2_latency1", m_valid, 0);
    cyc(1);
    chk("t2_latency2", m_valid, 1);
    chk("t2_first", m_data, 8'h20);
    wait_drain(100);
    cyc(2);
`endif

    // full buffer back-pressure
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 24; i++) write_word(8'(8'h40 + i));
    chk("t3_full_ready", wr_ready, 0);
    chk("t3_full_level", level, 24);
    wr_valid = 1'b1;
    wr_data  = 8'h58;
    cyc(5);
    chk("t3_no_overwrite", level, 24);
    wr_valid = 1'b0;
    m_ready  = 1'b1;
    begin
      int k = 0;
      while (frame_done !== 1'b1 && k < 200) begin
        cyc(1);
        k++;
      end
    end
    chk("t3_frame_done", frame_done, 1);
    chk("t3_level12", level, 12);
    m_ready = 1'b0;
    write_word(8'h58);
    chk("t3_level13", level, 13);

`ifndef MVM_TX_THROTTLE_EN
    // reset mid-frame, then a fresh frame from A0
    do_reset();
    for (int i = 0; i < 12; i++) write_word(8'(8'h60 + i));
    m_ready = 1'b1;
    cyc(1);
    chk("t5_first", m_data, 8'h60);
    cyc(5);
    chk("t5_sixth", m_data, 8'h65);
    reset = 1'b0;
    cyc(1);
    chk("t5_rst_valid", m_valid, 0);
    chk("t5_rst_level", level, 0);
    chk("t5_rst_data", m_data, 0);
    chk("t5_rst_done", frame_done, 0);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) write_word(8'(8'hA0 + i));
    chk("t5_wait", m_valid, 0);
    cyc(1);
    chk("t5_restart", m_data, 8'hA0);
    wait_drain(100);
`endif

    // random traffic: 5 frames
    do_reset();
    cyc(1);
    fd0 = fd_dut;
    wdone = 0;
    fork
      begin
        for (int i = 0; i < 5 * TOTAL; i++) begin
          cyc($urandom_range(0, 2));
          write_word(8'($urandom));
        end
        wdone = 1;
      end
      begin
        while (!wdone) begin
          m_ready = 1'($urandom_range(0, 1));
          cyc(1);
        end
      end
    join
    m_ready = 1'b1;
    wait_drain(1000);
    cyc(2);
    chk("t4_frames", fd_dut - fd0, 5);
    chk("t4_count", rd_cnt, 5 * TOTAL);

`ifdef MVM_TX_THROTTLE_EN
    // throttled streaming must still deliver in order, with gaps
    do_reset();
    m_ready = 1'b1;
    gap_cnt = 0;
    for (int i = 0; i < 3 * TOTAL; i++) write_word(8'(8'hC0 + i));
    wait_drain(2000);
    cyc(2);
    chk("t6_count", rd_cnt, 3 * TOTAL);
    chk("t6_gaps", gap_cnt > 0, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
